// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder slice.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder composed from two half-adder cells and an OR for carry-out.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module full_adder_cell
  import serial_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  half_adder u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
  half_adder u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

  // At most one of c0/c1 can be set, so OR equals the majority function.
  assign co = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic             c_reg;
  logic [CNT_W-1:0] cnt;
  logic             bit_s;
  logic             bit_co;
  logic             accept;
  logic             last_bit;

  full_adder_cell u_fa (
    .x  (shift_a[0]),
    .y  (shift_b[0]),
    .ci (c_reg),
    .s  (bit_s),
    .co (bit_co)
  );

  // A new request is only taken outside RUN; DONE accepts directly for back-to-back issue.
  assign accept   = start && (state != RUN);
  assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_a <= '0;
      shift_b <= '0;
      c_reg   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      carry   <= 1'b0;
    end else if (accept) begin
      shift_a <= a;
      shift_b <= b;
      c_reg   <= cin;
      cnt     <= '0;
    end else if (state == RUN) begin
      shift_a <= {1'b0, shift_a[WIDTH-1:1]};
      shift_b <= {1'b0, shift_b[WIDTH-1:1]};
      c_reg   <= bit_co;
      cnt     <= cnt + CNT_W'(1);
      // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
      sum     <= {bit_s, sum[WIDTH-1:1]};
      if (last_bit) carry <= bit_co;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the MSB edge c_reg is the carry into the MSB and bit_co the carry out of it.
  always_ff @(posedge clk) begin
    if (rst || accept) overflow <= 1'b0;
    else if (last_bit) overflow <= c_reg ^ bit_co;
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
`ifdef SERIAL_ADDER_OVF_EN
  logic         overflow;
`endif

  int vectors;
  int miscompares;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry    (carry)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one add and wait (bounded) for done; returns cycles to done and busy cycles seen.
  task automatic issue_and_wait(input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic vc, output int lat, output int busy_cnt);
    start = 1'b1; a = va; b = vb; cin = vc;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, sum, carry} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b sum=%h carry=%b, required 0 0 00 0", busy, done, sum, carry);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    issue_and_wait(8'h3C, 8'h0F, 1'b0, lat, bc);
    vectors++;
    if (lat !== 8) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d cycles, required 8", lat);
    end
    vectors++;
    if (bc !== 8) begin
      miscompares++;
      $display("FAIL basic_busy_cycles: got %0d, required 8", bc);
    end
    vectors++;
    if ({carry, sum} !== 9'h04B || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_sum: carry=%b sum=%h busy=%b, required 0 4b 0", carry, sum, busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || {carry, sum} !== 9'h04B) begin
      miscompares++;
      $display("FAIL basic_done_pulse: done=%b sum=%h, required 0 4b (held)", done, sum);
    end
  endtask

  task automatic test_carry_out();
    int lat, bc;
    issue_and_wait(8'hFF, 8'h01, 1'b0, lat, bc);
    vectors++;
    if (lat !== 8 || {carry, sum} !== 9'h100) begin
      miscompares++;
      $display("FAIL carry_ff_01: lat=%0d carry=%b sum=%h, required 8 1 00", lat, carry, sum);
    end
    @(negedge clk);
    issue_and_wait(8'hFF, 8'h00, 1'b1, lat, bc);
    vectors++;
    if (lat !== 8 || {carry, sum} !== 9'h100) begin
      miscompares++;
      $display("FAIL carry_ff_cin: lat=%0d carry=%b sum=%h, required 8 1 00", lat, carry, sum);
    end
    @(negedge clk);
    issue_and_wait(8'hAA, 8'h55, 1'b1, lat, bc);
    vectors++;
    if (lat !== 8 || {carry, sum} !== 9'h100) begin
      miscompares++;
      $display("FAIL carry_aa_55_cin: lat=%0d carry=%b sum=%h, required 8 1 00", lat, carry, sum);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int lat;
    int extra;
    start = 1'b1; a = 8'h3C; b = 8'h0F; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    repeat (2) begin @(negedge clk); lat++; end
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b1;
    @(negedge clk); lat++;
    start = 1'b0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    vectors++;
    if (lat !== 8 || {carry, sum} !== 9'h04B) begin
      miscompares++;
      $display("FAIL ignored_start_result: lat=%0d carry=%b sum=%h, required 8 0 4b", lat, carry, sum);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL ignored_start_second_op: got %0d active cycles, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic [W:0]   exp [3];
    int gap;
    va[0] = 8'h12; vb[0] = 8'h34; vc[0] = 1'b0; exp[0] = 9'h046;
    va[1] = 8'hA5; vb[1] = 8'h5A; vc[1] = 1'b1; exp[1] = 9'h100;
    va[2] = 8'h80; vb[2] = 8'h81; vc[2] = 1'b0; exp[2] = 9'h101;
    start = 1'b1; a = va[0]; b = vb[0]; cin = vc[0];
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin a = va[i+1]; b = vb[i+1]; cin = vc[i+1]; end
      else start = 1'b0;
      // Gap counts cycles from the accept edge to the done cycle; done-to-done is gap+1.
      gap = 0;
      while (!done && gap < 20) begin @(negedge clk); gap++; end
      vectors++;
      if (gap !== 8 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_spacing[%0d]: gap=%0d busy=%b, required 8 0", i, gap, busy);
      end
      vectors++;
      if ({carry, sum} !== exp[i]) begin
        miscompares++;
        $display("FAIL b2b_sum[%0d]: carry_sum=%h, required %h", i, {carry, sum}, exp[i]);
      end
      @(negedge clk);
      if (i < 2) begin
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_reissue[%0d]: busy=%b done=%b, required 1 0", i, busy, done);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle_after: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_op();
    int extra;
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({busy, done, sum, carry} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_op: busy=%b done=%b sum=%h carry=%b, required 0 0 00 0", busy, done, sum, carry);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_op_no_done: got %0d active cycles, required 0", extra);
    end
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_overflow();
    int lat, bc;
    issue_and_wait(8'h7F, 8'h01, 1'b0, lat, bc);
    vectors++;
    if ({carry, sum, overflow} !== {1'b0, 8'h80, 1'b1}) begin
      miscompares++;
      $display("FAIL ovf_7f_01: carry=%b sum=%h ovf=%b, required 0 80 1", carry, sum, overflow);
    end
    @(negedge clk);
    issue_and_wait(8'h80, 8'h80, 1'b0, lat, bc);
    vectors++;
    if ({carry, sum, overflow} !== {1'b1, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL ovf_80_80: carry=%b sum=%h ovf=%b, required 1 00 1", carry, sum, overflow);
    end
    @(negedge clk);
    issue_and_wait(8'h3C, 8'h0F, 1'b0, lat, bc);
    vectors++;
    if ({carry, sum, overflow} !== {1'b0, 8'h4B, 1'b0}) begin
      miscompares++;
      $display("FAIL ovf_none: carry=%b sum=%h ovf=%b, required 0 4b 0", carry, sum, overflow);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry_out();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_op();
`ifdef SERIAL_ADDER_OVF_EN
    test_overflow();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
